// File: rtl/emisor_pixeles_pkg.sv
// emisor_pixeles_pkg: shared FSM encoding and size constants for the raster pixel streamer.
// Rev 1.0
`default_nettype none

package emisor_pixeles_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    LEYENDO  = 2'd1,
    VACIANDO = 2'd2
  } estado_t;

  localparam int VENTANA_MIN = 5;
  localparam int ANCHO_DEF   = 640;
  localparam int ALTO_DEF    = 480;

endpackage

`default_nettype wire

// File: rtl/emisor_pixeles_buffer_salida_2.sv
// buffer_salida_2: two-entry FIFO whose head is exposed combinationally; push and pop may coincide.
// Rev 1.0
`default_nettype none

module buffer_salida_2 #(
  parameter int ANCHO = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [ANCHO-1:0] dato_entrada,
  output logic [ANCHO-1:0] cabeza,
  output logic [1:0]       cuenta
);

  logic [ANCHO-1:0] cola;
  logic             pop_ok;
  logic             push_ok;

  // Guards keep the entry count consistent even if a caller misbehaves.
  assign pop_ok  = pop && (cuenta != 2'd0);
  assign push_ok = push && ((cuenta != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cabeza <= '0;
      cola   <= '0;
      cuenta <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cuenta == 2'd0) cabeza <= dato_entrada;
          else                cola   <= dato_entrada;
          cuenta <= cuenta + 2'd1;
        end
        2'b01: begin
          cabeza <= cola;
          cuenta <= cuenta - 2'd1;
        end
        2'b11: begin
          if (cuenta == 2'd1) begin
            cabeza <= dato_entrada;
          end else begin
            cabeza <= cola;
            cola   <= dato_entrada;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/emisor_pixeles.sv
// emisor_pixeles: streams a stored frame in raster order from a 1-cycle-latency memory to the window.
// Rev 1.0
`default_nettype none

module emisor_pixeles
  import emisor_pixeles_pkg::*;
#(
  parameter int BITS_PIXEL = 8,
  parameter int ANCHO_MAX  = ANCHO_DEF,
  parameter int ALTO_MAX   = ALTO_DEF,
  parameter int BITS_COL   = 10,
  parameter int BITS_FIL   = 9,
  parameter int BITS_DIR   = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [BITS_COL-1:0]   ancho_imagen,
  input  logic [BITS_FIL-1:0]   alto_imagen,
  output logic [BITS_DIR-1:0]   mem_dir,
  output logic                  mem_leer,
  input  logic [BITS_PIXEL-1:0] mem_dato,
  output logic [BITS_PIXEL-1:0] pixel_salida,
  output logic                  pixel_valido,
  input  logic                  listo_ventana,
  output logic                  fin_linea,
  output logic                  fin_imagen,
  output logic                  ocupado,
  output logic                  error_config
);

  estado_t               estado;
  estado_t               estado_sig;
  logic [BITS_COL-1:0]   ancho;
  logic [BITS_COL-1:0]   col;
  logic [BITS_FIL-1:0]   alto;
  logic [BITS_FIL-1:0]   fil;
  logic [BITS_DIR-1:0]   dir;
  logic                  en_vuelo;
  logic                  vuelo_fl;
  logic                  vuelo_fi;
  logic [1:0]            cuenta;
  logic [BITS_PIXEL+1:0] cabeza;
  logic [2:0]            ocupacion_sig;
  logic                  config_ok;
  logic                  aceptar;
  logic                  rechazar;
  logic                  transferencia;
  logic                  ultima_col;
  logic                  ultima_fil;

  assign config_ok = (ancho_imagen >= BITS_COL'(VENTANA_MIN)) &&
                     (alto_imagen  >= BITS_FIL'(VENTANA_MIN)) &&
                     (ancho_imagen <= BITS_COL'(ANCHO_MAX))   &&
                     (alto_imagen  <= BITS_FIL'(ALTO_MAX));
  assign aceptar  = (estado == REPOSO) && iniciar && config_ok;
  assign rechazar = (estado == REPOSO) && iniciar && !config_ok;

  assign pixel_valido  = (cuenta != 2'd0);
  assign transferencia = pixel_valido && listo_ventana;
  assign pixel_salida  = cabeza[BITS_PIXEL-1:0];
  assign fin_linea     = pixel_valido && cabeza[BITS_PIXEL+1];
  assign fin_imagen    = pixel_valido && cabeza[BITS_PIXEL];
  assign ocupado       = (estado != REPOSO);
  assign mem_dir       = dir;

  // A new read only goes out if its data is guaranteed a free slot when it returns.
  assign ocupacion_sig = {1'b0, cuenta} - {2'b00, transferencia} + {2'b00, en_vuelo};
  assign mem_leer      = (estado == LEYENDO) && (ocupacion_sig < 3'd2);

  assign ultima_col = (col == ancho - BITS_COL'(1));
  assign ultima_fil = (fil == alto - BITS_FIL'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:   if (aceptar) estado_sig = LEYENDO;
      LEYENDO:  if (mem_leer && ultima_col && ultima_fil) estado_sig = VACIANDO;
      VACIANDO: if (transferencia && fin_imagen) estado_sig = REPOSO;
      default:  estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ancho        <= '0;
      alto         <= '0;
      col          <= '0;
      fil          <= '0;
      dir          <= '0;
      en_vuelo     <= 1'b0;
      vuelo_fl     <= 1'b0;
      vuelo_fi     <= 1'b0;
      error_config <= 1'b0;
    end else begin
      error_config <= rechazar;
      en_vuelo     <= mem_leer;
      if (aceptar) begin
        ancho <= ancho_imagen;
        alto  <= alto_imagen;
        col   <= '0;
        fil   <= '0;
        dir   <= '0;
      end else if (mem_leer) begin
        // Markers travel with the read so they line up with the returning pixel.
        vuelo_fl <= ultima_col;
        vuelo_fi <= ultima_col && ultima_fil;
        dir      <= dir + BITS_DIR'(1);
        if (ultima_col) begin
          col <= '0;
          fil <= fil + BITS_FIL'(1);
        end else begin
          col <= col + BITS_COL'(1);
        end
      end
    end
  end

  buffer_salida_2 #(
    .ANCHO (BITS_PIXEL + 2)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .push         (en_vuelo),
    .pop          (transferencia),
    .dato_entrada ({vuelo_fl, vuelo_fi, mem_dato}),
    .cabeza       (cabeza),
    .cuenta       (cuenta)
  );

endmodule

`default_nettype wire

// File: tb/tb_emisor_pixeles.sv
// tb_emisor_pixeles: random-backpressure bench checking raster order, markers, latency and control.
// Rev 1.0
`default_nettype none

module tb_emisor_pixeles;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic [9:0]  ancho_imagen = '0;
  logic [8:0]  alto_imagen = '0;
  logic [18:0] mem_dir;
  logic        mem_leer;
  logic [7:0]  mem_dato = '0;
  logic [7:0]  pixel_salida;
  logic        pixel_valido;
  logic        listo_ventana = 1'b0;
  logic        fin_linea;
  logic        fin_imagen;
  logic        ocupado;
  logic        error_config;

  emisor_pixeles dut (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .ancho_imagen  (ancho_imagen),
    .alto_imagen   (alto_imagen),
    .mem_dir       (mem_dir),
    .mem_leer      (mem_leer),
    .mem_dato      (mem_dato),
    .pixel_salida  (pixel_salida),
    .pixel_valido  (pixel_valido),
    .listo_ventana (listo_ventana),
    .fin_linea     (fin_linea),
    .fin_imagen    (fin_imagen),
    .ocupado       (ocupado),
    .error_config  (error_config)
  );

  always #5 clk = ~clk;

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  int checks = 0;
  int errors = 0;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: obtenido %0d esperado %0d (ciclo %0d)", tag, obs, esp, ciclo);
    end
  endtask

  // Frame memory: word at address a holds a mod 256; data is only meaningful one cycle after a read.
  initial begin
    logic        l;
    logic [18:0] d;
    forever begin
      @(negedge clk);
      l = mem_leer;
      d = mem_dir;
      @(posedge clk);
      #1;
      mem_dato = l ? d[7:0] : 8'($urandom);
    end
  end

  // Backpressure: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready.
  int modo = 0;
  int fase = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (modo)
        0: listo_ventana = 1'b1;
        1: listo_ventana = (fase % 3 == 0);
        2: listo_ventana = 1'($urandom);
        default: listo_ventana = 1'b0;
      endcase
      fase++;
    end
  end

  // Reference model state: the k-th transferred pixel must be raster pixel k.
  bit         mon_on = 0;
  int         w_act = 5, h_act = 5;
  int         k, lecturas, n_fl, n_fi, t_fin, primer_leer, primer_valido, ultima_dir;
  bit         fin_visto, prev_stall, prev_fin;
  logic [7:0] prev_pix;
  logic       prev_fl, prev_fi;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (prev_fin) chequear("ocupado_baja", 32'(ocupado), 0);
        prev_fin = 0;
        chequear("sin_error", 32'(error_config), 0);
        if (prev_stall) begin
          chequear("estable_valido", 32'(pixel_valido), 1);
          chequear("estable_pixel", 32'(pixel_salida), 32'(prev_pix));
          chequear("estable_fl", 32'(fin_linea), 32'(prev_fl));
          chequear("estable_fi", 32'(fin_imagen), 32'(prev_fi));
        end
        if (mem_leer) begin
          if (primer_leer < 0) primer_leer = ciclo;
          chequear("mem_dir", 32'(mem_dir), lecturas);
          ultima_dir = int'(mem_dir);
          lecturas++;
        end
        if (pixel_valido && primer_valido < 0) primer_valido = ciclo;
        if (pixel_valido && listo_ventana) begin
          chequear("pixel", 32'(pixel_salida), k % 256);
          chequear("fin_linea", 32'(fin_linea), 32'((k % w_act) == w_act - 1));
          chequear("fin_imagen", 32'(fin_imagen), 32'(k == w_act * h_act - 1));
          if (fin_linea) n_fl++;
          if (fin_imagen) begin
            n_fi++;
            fin_visto = 1;
            t_fin = ciclo;
            prev_fin = 1;
          end
          k++;
        end
        chequear("sin_desborde", 32'((lecturas - k) <= 2), 1);
        prev_stall = pixel_valido && !listo_ventana;
        prev_pix = pixel_salida;
        prev_fl = fin_linea;
        prev_fi = fin_imagen;
      end
    end
  end

  task automatic chequear_ceros(input string tag);
    chequear({tag, "_dir"}, 32'(mem_dir), 0);
    chequear({tag, "_leer"}, 32'(mem_leer), 0);
    chequear({tag, "_pixel"}, 32'(pixel_salida), 0);
    chequear({tag, "_valido"}, 32'(pixel_valido), 0);
    chequear({tag, "_fl"}, 32'(fin_linea), 0);
    chequear({tag, "_fi"}, 32'(fin_imagen), 0);
    chequear({tag, "_ocupado"}, 32'(ocupado), 0);
    chequear({tag, "_error"}, 32'(error_config), 0);
  endtask

  task automatic preparar_modelo(input int w, input int h, input int m);
    modo = m;
    fase = 0;
    w_act = w;
    h_act = h;
    k = 0; lecturas = 0; n_fl = 0; n_fi = 0; t_fin = -1; ultima_dir = -1;
    primer_leer = -1; primer_valido = -1;
    fin_visto = 0; prev_stall = 0; prev_fin = 0;
    mon_on = 1;
  endtask

  task automatic run_frame(input int w, input int h, input int m, input bit pulsos);
    int t_ini;
    bit acabado;
    preparar_modelo(w, h, m);
    @(posedge clk);
    #1;
    ancho_imagen = 10'(w);
    alto_imagen = 9'(h);
    iniciar = 1'b1;
    t_ini = ciclo;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    if (pulsos) begin
      repeat (8) @(posedge clk);
      #1;
      iniciar = 1'b1;
      @(posedge clk);
      #1;
      iniciar = 1'b0;
      // Land a request exactly in the cycle that transfers the last pixel.
      while (ciclo < t_ini + 2 + w * h) begin
        @(posedge clk);
        #1;
      end
      iniciar = 1'b1;
      @(posedge clk);
      #1;
      iniciar = 1'b0;
    end
    acabado = 0;
    for (int i = 0; i < 4 * w * h + 50 && !acabado; i++) begin
      @(negedge clk);
      #1;
      if (fin_visto && !ocupado) acabado = 1;
    end
    chequear("fin_a_tiempo", 32'(acabado), 1);
    chequear("num_pixeles", k, w * h);
    chequear("n_fin_linea", n_fl, h);
    chequear("n_fin_imagen", n_fi, 1);
    chequear("ultima_dir", ultima_dir, w * h - 1);
    chequear("num_lecturas", lecturas, w * h);
    chequear("lat_leer", primer_leer, t_ini + 1);
    chequear("lat_valido", primer_valido, t_ini + 3);
    if (m == 0) chequear("rendimiento", t_fin, t_ini + 2 + w * h);
    repeat (4) begin
      @(negedge clk);
      #1;
      chequear("reposo_leer", 32'(mem_leer), 0);
      chequear("reposo_ocupado", 32'(ocupado), 0);
    end
    mon_on = 0;
  endtask

  task automatic probar_error(input int w, input int h);
    int n_err, n_leer, n_ocup;
    n_err = 0; n_leer = 0; n_ocup = 0;
    @(posedge clk);
    #1;
    ancho_imagen = 10'(w);
    alto_imagen = 9'(h);
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_err += int'(error_config);
      n_leer += int'(mem_leer);
      n_ocup += int'(ocupado);
    end
    chequear("error_pulso", n_err, 1);
    chequear("error_sin_leer", n_leer, 0);
    chequear("error_sin_ocupado", n_ocup, 0);
  endtask

  initial begin
    bit llego;
    repeat (3) @(negedge clk);
    chequear_ceros("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chequear_ceros("post_reset");

    run_frame(5, 5, 0, 0);
    run_frame(5, 5, 1, 0);
    probar_error(4, 8);
    probar_error(641, 5);
    probar_error(5, 4);
    probar_error(5, 481);
    run_frame(640, 8, 0, 0);
    run_frame(5, 480, 0, 0);
    for (int r = 0; r < 4; r++)
      run_frame(int'($urandom_range(5, 12)), int'($urandom_range(5, 9)), 2, 0);

    // Abort mid-frame with the buffer held full, then restart cleanly.
    preparar_modelo(5, 5, 0);
    @(posedge clk);
    #1;
    ancho_imagen = 10'd5;
    alto_imagen = 9'd5;
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    iniciar = 1'b0;
    llego = 0;
    for (int i = 0; i < 100 && !llego; i++) begin
      @(negedge clk);
      #1;
      if (k >= 12) llego = 1;
    end
    chequear("llega_pixel_12", 32'(llego), 1);
    modo = 3;
    repeat (4) @(posedge clk);
    #1;
    mon_on = 0;
    chequear("lleno_valido", 32'(pixel_valido), 1);
    reset = 1'b0;
    #1;
    chequear_ceros("abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    modo = 0;
    repeat (3) begin
      @(negedge clk);
      chequear_ceros("tras_abort");
    end
    run_frame(5, 5, 0, 0);

    run_frame(5, 5, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
